// File: rtl/com_pkg.sv
// Shared constants for the UART memory-debug channel: ASCII codes, FSM states, helpers.
// No latency: package only, no logic.
// No backpressure: package only.
package com_pkg;

  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_COLON = 8'h3A;
  localparam logic [7:0] CHAR_0     = 8'h30;
  localparam logic [7:0] CHAR_A     = 8'h41;

  // Response FSM state encoding.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_LOAD     = 3'd2,
    ST_SEND     = 3'd3,
    ST_ACK      = 3'd4,
    ST_DRAIN    = 3'd5
  } state_t;

  // Bits needed to count 0..value-1; never less than 1 so counters stay legal.
  function automatic int clog2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_to_com_hex_nibble_to_ascii.sv
// Converts a 4-bit nibble to its uppercase ASCII hex character.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module nibble_to_ascii
  import com_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] chr
);

  // Digits count up from '0', letters from 'A'.
  always_comb begin
    if (nib < 4'd10) chr = CHAR_0 + {4'h0, nib};
    else             chr = CHAR_A + {4'h0, nib} - 8'd10;
  end

endmodule

// File: rtl/mem_to_com_hex.sv
// Reads one BRAM word per request and streams it to UART_TX as uppercase hex + CR LF.
// Latency: handshake to first tx_start is 1 + MEM_LAT + 2 clocks when UART_TX is idle.
// Backpressure: req_ready low while a response is in flight (requests dropped); bytes wait on tx_busy.
// Optional MEM_TO_COM_ECHO_ADDR_EN: prefix each response with the hex address and ':'.
module mem_to_com_hex
  import com_pkg::*;
#(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 12,
  parameter int MEM_LAT = 1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy
);

  localparam int DNIB = DATA_W / 4;
`ifdef MEM_TO_COM_ECHO_ADDR_EN
  localparam int ANIB = (ADDR_W + 3) / 4;
  localparam int AW4  = ANIB * 4;
  localparam int PRE  = ANIB + 1;
`else
  localparam int PRE  = 0;
`endif
  localparam int NCHAR = PRE + DNIB + 2;
  localparam int IDX_W = clog2(NCHAR);

`ifdef MEM_TO_COM_ECHO_ADDR_EN
  localparam logic [IDX_W-1:0] IDX_COLON = IDX_W'(ANIB);
`endif
  localparam logic [IDX_W-1:0] IDX_CR    = IDX_W'(PRE + DNIB);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NCHAR - 1);
  localparam logic [1:0]       WAIT_LAST = 2'(MEM_LAT);

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        wcnt;
  logic [DATA_W-1:0] data_sr;
  logic [3:0]        nib;
  logic [7:0]        nib_chr;
  logic [7:0]        char_sel;
`ifdef MEM_TO_COM_ECHO_ADDR_EN
  logic [AW4-1:0]    addr_sr;
`endif

  assign req_ready = (state == ST_IDLE);
  assign busy      = ~req_ready;

  // Nibble feeding the converter: address digits first when echoing, else data digits.
  always_comb begin
    nib = data_sr[DATA_W-1 -: 4];
`ifdef MEM_TO_COM_ECHO_ADDR_EN
    if (idx < IDX_COLON) nib = addr_sr[AW4-1 -: 4];
`endif
  end

  nibble_to_ascii u_n2a (
    .nib (nib),
    .chr (nib_chr)
  );

  // Character for the current index: hex digit, separator, CR or LF.
  always_comb begin
    char_sel = CHAR_LF;
`ifdef MEM_TO_COM_ECHO_ADDR_EN
    if (idx == IDX_COLON)   char_sel = CHAR_COLON;
    else if (idx < IDX_CR)  char_sel = nib_chr;
`else
    if (idx < IDX_CR)       char_sel = nib_chr;
`endif
    else if (idx == IDX_CR) char_sel = CHAR_CR;
  end

  // State register; async reset abandons any response in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: one byte per LOAD/SEND/ACK/DRAIN loop, gated by tx_busy.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (req_valid) state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: if (wcnt == WAIT_LAST) state_nxt = ST_LOAD;
      ST_LOAD:     state_nxt = ST_SEND;
      ST_SEND:     if (!tx_busy) state_nxt = ST_ACK;
      ST_ACK:      if (tx_busy) state_nxt = ST_DRAIN;
      ST_DRAIN:    if (!tx_busy) state_nxt = (idx == IDX_LAST) ? ST_IDLE : ST_LOAD;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: request latch, BRAM strobe, single data capture, byte load and start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      wcnt      <= '0;
      idx       <= '0;
      data_sr   <= '0;
`ifdef MEM_TO_COM_ECHO_ADDR_EN
      addr_sr   <= '0;
`endif
    end else begin
      mem_rd_en <= 1'b0;
      tx_start  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            mem_addr  <= req_addr;
            mem_rd_en <= 1'b1;
            wcnt      <= '0;
          end
        end
        ST_MEM_WAIT: begin
          // The extra cycle covers the strobe itself; data is valid MEM_LAT cycles after it.
          if (wcnt == WAIT_LAST) begin
            data_sr <= mem_data;
            idx     <= '0;
`ifdef MEM_TO_COM_ECHO_ADDR_EN
            addr_sr <= AW4'(mem_addr);
`endif
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        ST_LOAD: begin
          tx_data <= char_sel;
`ifdef MEM_TO_COM_ECHO_ADDR_EN
          if (idx < IDX_COLON)                        addr_sr <= addr_sr << 4;
          else if (idx > IDX_COLON && idx < IDX_CR)   data_sr <= data_sr << 4;
`else
          if (idx < IDX_CR)                           data_sr <= data_sr << 4;
`endif
        end
        ST_SEND: begin
          if (!tx_busy) tx_start <= 1'b1;
        end
        ST_DRAIN: begin
          if (!tx_busy && idx != IDX_LAST) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_to_com_hex.sv
module tb_mem_to_com_hex;

  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 12;
  localparam int MEM_LAT = 1;
  localparam int DNIB    = DATA_W / 4;
`ifdef MEM_TO_COM_ECHO_ADDR_EN
  localparam int ANIB  = (ADDR_W + 3) / 4;
  localparam int NCHAR = ANIB + 1 + DNIB + 2;
`else
  localparam int NCHAR = DNIB + 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_ready;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              busy;

  int tests = 0;
  int fails = 0;

  mem_to_com_hex #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .busy(busy)
  );

  always #5 clk = ~clk;

  // BRAM model: data is valid only MEM_LAT cycles after the strobe, noise otherwise.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] p_addr = '0;
  logic              p_vld = 1'b0;
  int                rd_cnt = 0;
  always @(posedge clk) begin
    p_addr <= mem_addr;
    p_vld  <= mem_rd_en;
    if (mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (MEM_LAT == 1) mem_data <= mem_rd_en ? mem[mem_addr] : DATA_W'($urandom);
    else              mem_data <= p_vld ? mem[p_addr] : DATA_W'($urandom);
  end

  // UART_TX model: accepts a byte on tx_start, then busy for busy_len cycles.
  int         bcnt = 0;
  int         busy_len = 10;
  logic       hold_busy = 1'b0;
  logic       prev_start = 1'b0;
  logic [7:0] got [$];
  int         starts = 0;
  int         viol_cnt = 0;
  int         unst_cnt = 0;
  bit         mon_en = 1'b1;
  assign tx_busy = hold_busy | (bcnt != 0);
  always @(posedge clk) begin
    prev_start <= tx_start;
    if (tx_start && (prev_start || tx_busy)) viol_cnt <= viol_cnt + 1;
    if (mon_en && bcnt != 0 && got.size() > 0 && tx_data !== got[$]) unst_cnt <= unst_cnt + 1;
    if (tx_start) begin
      starts <= starts + 1;
      got.push_back(tx_data);
      bcnt <= busy_len;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
    end
  end

  // Reference: expected response bytes computed from the value with plain arithmetic.
  logic [7:0] exp_q [$];
  function automatic logic [7:0] hexc(input int n);
    if (n < 10) return 8'(48 + n);
    return 8'(55 + n);
  endfunction
  function automatic void build_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.delete();
`ifdef MEM_TO_COM_ECHO_ADDR_EN
    for (int k = ANIB - 1; k >= 0; k--) exp_q.push_back(hexc(int'((32'(a) >> (4 * k)) & 32'hF)));
    exp_q.push_back(8'h3A);
`endif
    for (int k = DNIB - 1; k >= 0; k--) exp_q.push_back(hexc(int'((32'(d) >> (4 * k)) & 32'hF)));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic issue(input logic [ADDR_W-1:0] a);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_req(input string nm, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input int pre_busy, input bit inject);
    int base, s0, r0, v0, u0, lat, exp_lat, inj, early, hold_bad;
    bit done;
    mem[a] = d;
    build_exp(a, d);
    base = got.size(); s0 = starts; r0 = rd_cnt; v0 = viol_cnt; u0 = unst_cnt;
    lat = -1; inj = 0; early = 0; hold_bad = 0; done = 1'b0;
    if (pre_busy > 0) hold_busy = 1'b1;
    issue(a);
    tests++;
    if (mem_rd_en !== 1'b1 || mem_addr !== a) begin
      fails++; $display("FAIL %s_rd_strobe: rd_en=%b addr=%h, required rd_en=1 addr=%h", nm, mem_rd_en, mem_addr, a);
    end
    tests++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      fails++; $display("FAIL %s_busy: busy=%b req_ready=%b, required 1/0", nm, busy, req_ready);
    end
    for (int cyc = 1; cyc <= 4000 && !done; cyc++) begin
      @(posedge clk); #1;
      if (lat < 0 && tx_start) lat = cyc;
      if (cyc == 1 + MEM_LAT) mem[a] = ~d;
      if (hold_busy && cyc >= 2 + MEM_LAT && tx_data !== exp_q[0]) hold_bad++;
      if (pre_busy > 0 && cyc == pre_busy) hold_busy = 1'b0;
      if (inject) begin
        if (inj < 3 && got.size() >= base + 3) begin
          req_valid = 1'b1; req_addr = 1; inj++;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (req_ready && got.size() < base + NCHAR) early++;
      if (got.size() == base + NCHAR && req_ready) done = 1'b1;
    end
    req_valid = 1'b0;
    hold_busy = 1'b0;
    tests++;
    if (!done) begin
      fails++; $display("FAIL %s_timeout: bytes=%0d, required %0d within budget", nm, got.size() - base, NCHAR);
    end
    tests++;
    if (starts - s0 != NCHAR) begin
      fails++; $display("FAIL %s_start_count: got %0d, required %0d", nm, starts - s0, NCHAR);
    end
    tests++;
    if (rd_cnt - r0 != 1) begin
      fails++; $display("FAIL %s_rd_count: got %0d, required 1", nm, rd_cnt - r0);
    end
    tests++;
    if (viol_cnt != v0 || unst_cnt != u0) begin
      fails++; $display("FAIL %s_tx_protocol: violations=%0d unstable=%0d, required 0/0", nm, viol_cnt - v0, unst_cnt - u0);
    end
    exp_lat = (pre_busy + 1 > 3 + MEM_LAT) ? pre_busy + 1 : 3 + MEM_LAT;
    tests++;
    if (lat != exp_lat) begin
      fails++; $display("FAIL %s_first_start_latency: got %0d, required %0d", nm, lat, exp_lat);
    end
    if (pre_busy >= 2 + MEM_LAT) begin
      tests++;
      if (hold_bad != 0) begin
        fails++; $display("FAIL %s_hold_tx_data: %0d unstable cycles, required 0", nm, hold_bad);
      end
    end
    for (int i = 0; i < NCHAR; i++) begin
      tests++;
      if (base + i >= got.size()) begin
        fails++; $display("FAIL %s_byte%0d: missing, required %h", nm, i, exp_q[i]);
      end else if (got[base + i] !== exp_q[i]) begin
        fails++; $display("FAIL %s_byte%0d: got %h, required %h", nm, i, got[base + i], exp_q[i]);
      end
    end
    tests++;
    if (early != 0 || busy !== 1'b0 || tx_busy !== 1'b0) begin
      fails++; $display("FAIL %s_ready_return: early=%0d busy=%b tx_busy=%b, required 0/0/0", nm, early, busy, tx_busy);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_ready: req_ready=%b busy=%b, required 1/0", req_ready, busy);
    end
    tests++;
    if (mem_rd_en !== 1'b0 || mem_addr !== '0 || tx_start !== 1'b0 || tx_data !== 8'h00) begin
      fails++; $display("FAIL reset_outputs: rd_en=%b addr=%h start=%b data=%h, required 0/0/0/00",
                        mem_rd_en, mem_addr, tx_start, tx_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    busy_len = 10;
    run_req("basic", 17'h00055, 12'h255, 0, 1'b0);
  endtask

  task automatic test_max_addr();
    busy_len = 10;
    run_req("max_addr", 17'h1FFFF, 12'hABC, 0, 1'b0);
  endtask

  task automatic test_ignore();
    busy_len = 10;
    mem[1] = 12'hFED;
    run_req("ignored_req", 17'h00123, 12'h9E1, 0, 1'b1);
  endtask

  task automatic test_busy_stuck();
    busy_len = 10;
    run_req("busy_stuck", 17'h0A5A5, 12'h3C7, 500, 1'b0);
  endtask

  task automatic test_reset_mid();
    int base, s0;
    busy_len = 10;
    mem[17'h00777] = 12'h5A3;
    base = got.size();
    issue(17'h00777);
    for (int c = 0; c < 500 && got.size() < base + 2; c++) begin
      @(posedge clk); #1;
    end
    tests++;
    if (got.size() < base + 2) begin
      fails++; $display("FAIL rst_mid_reach: bytes=%0d, required 2", got.size() - base);
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 ||
        mem_rd_en !== 1'b0 || mem_addr !== '0) begin
      fails++; $display("FAIL rst_mid_outputs: ready=%b busy=%b start=%b data=%h rd_en=%b addr=%h, required 1/0/0/00/0/0",
                        req_ready, busy, tx_start, tx_data, mem_rd_en, mem_addr);
    end
    s0 = starts;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 100 && tx_busy; c++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    tests++;
    if (starts != s0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid_abandon: new_starts=%0d ready=%b, required 0/1", starts - s0, req_ready);
    end
    mon_en = 1'b1;
    run_req("after_reset", 17'h00000, 12'h000, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      busy_len = $urandom_range(1, 12);
      run_req("random", ADDR_W'($urandom), DATA_W'($urandom), $urandom_range(0, 6), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_addr();
    test_ignore();
    test_busy_stuck();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_to_com_hex.md
Name: mem_to_com_hex

Overview:
Read-response path of the UART memory-debug channel. It accepts a read request (word address) from the command FSM and fetches the word from BRAM. It formats the word as uppercase ASCII hex followed by CR LF, and streams the bytes one at a time into the UART transmitter. It sits between the command parser/BRAM port B and the UART_TX instance in the top level.

Parameters:
ADDR_W, 17, BRAM word-address width (address is 5 hex digits on the wire)
DATA_W, 12, BRAM word width; must be a multiple of 4 (12 = RGB444 pixel)
MEM_LAT, 1, BRAM read latency in clocks (1 or 2)

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  read request strobe from the command FSM
req_addr  in  ADDR_W  word address to read
req_ready  out  1  high when idle and able to accept a request
mem_rd_en  out  1  BRAM read enable, one-cycle pulse
mem_addr  out  ADDR_W  BRAM read address, registered
mem_data  in  DATA_W  BRAM read data, valid MEM_LAT cycles after mem_rd_en
tx_data  out  8  byte to UART_TX
tx_start  out  1  one-cycle start pulse to UART_TX
tx_busy  in  1  UART_TX busy flag
busy  out  1  response in progress; equals ~req_ready

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. Every register clears immediately when rst_n=0.
- Reset values: req_ready=1, busy=0, mem_rd_en=0, mem_addr=0, tx_start=0, tx_data=8'h00, FSM=IDLE, char counter=0.
- A handshake occurs when req_valid & req_ready are both high. req_addr is captured on that edge.
- A req_valid that arrives while req_ready=0 is ignored and dropped; it is not queued.
- FSM states:
  - IDLE: req_ready=1. On handshake, latch mem_addr, pulse mem_rd_en for 1 cycle, go to MEM_WAIT.
  - MEM_WAIT: count MEM_LAT cycles, capture mem_data into a DATA_W shift register, set char index=0, go to LOAD.
  - LOAD: build tx_data from the current char index, go to SEND.
  - SEND: if tx_busy=0, pulse tx_start for 1 cycle with tx_data stable, go to ACK. Otherwise stay in SEND.
  - ACK: wait for tx_busy=1, then go to DRAIN.
  - DRAIN: wait for tx_busy=0. If the last char has been sent, go to IDLE; otherwise increment the index and go to LOAD.
- Character sequence: DATA_W/4 hex digits MSB nibble first, then 8'h0D, then 8'h0A. Total is NCHAR = DATA_W/4 + 2 (5 at the default).
- Nibble encoding: 0-9 map to 8'h30+n; 10-15 map to 8'h41+(n-10), i.e. uppercase.
- tx_data holds its value from LOAD through DRAIN. tx_start is never high for 2 consecutive cycles.
- Latency from handshake to the first tx_start is 1 + MEM_LAT + 2 cycles when tx_busy=0.
- tx_busy stuck at 1: the FSM stays in SEND or DRAIN indefinitely with no timeout. busy stays 1.
- tx_busy already high on entry to SEND: no start is issued until it falls.
- Reset mid-response: the transmission is abandoned and the FSM returns to IDLE. A byte already handed to UART_TX completes on its own.
- mem_data is sampled exactly once per request; later BRAM writes to the same address do not affect the response in flight.

Optional Feature:
- Macro: MEM_TO_COM_ECHO_ADDR_EN.
- Defined: each response is prefixed with ceil(ADDR_W/4) hex digits of the address (MSB first), then 8'h3A (':'). NCHAR grows by ceil(ADDR_W/4)+1; at the default that is 11 chars. The address is taken from the latched mem_addr, zero-extended to a nibble multiple.
- Not defined: data digits plus CR LF only, and the address-nibble logic is absent.

Decomposition:
- Shared package/header com_pkg:
  - ASCII constants CHAR_CR=8'h0D, CHAR_LF=8'h0A, CHAR_COLON=8'h3A, CHAR_0=8'h30, CHAR_A=8'h41.
  - The FSM state encoding localparams.
  - Function clog2.
- One natural sub-module: nibble_to_ascii (combinational 4-bit to 8-bit), also reusable by the hex command parser's inverse checks.

Test Plan:
- mem[0x00055]=0x255, req_addr=0x00055 pulse; UART_TX model with 10-cycle busy -> tx_data bytes 0x32,0x35,0x35,0x0D,0x0A in order. Exactly 5 tx_start pulses. req_ready returns to 1 after the last busy fall.
- mem[0x1FFFF]=0xABC -> bytes 0x41,0x42,0x43,0x0D,0x0A. mem_addr=0x1FFFF. mem_rd_en is high for exactly 1 cycle, MEM_LAT cycles before capture.
- Second req_valid, addr 0x00001, issued during the 3rd byte -> ignored. No extra mem_rd_en pulse; output stream is unchanged.
- tx_busy held high for 500 cycles before the first byte -> tx_start stays 0 throughout; first pulse arrives 1 cycle after busy falls; tx_data stays stable.
- rst_n low for 3 cycles during DRAIN of byte 2 -> outputs return to reset values immediately. A new request for 0x00000 (data 0x000) then yields 0x30,0x30,0x30,0x0D,0x0A.
- With MEM_TO_COM_ECHO_ADDR_EN, mem[0x00055]=0x255 -> "00055:255" then CR LF, i.e. 0x30,0x30,0x30,0x35,0x35,0x3A,0x32,0x35,0x35,0x0D,0x0A.
